// File: rtl/multi_input_capture_if.sv
// Scan/capture bus between an ADC front end and multi_input_capture.
// Carries scan control, sample strobe, hold readback and update strobe.
interface multi_input_capture_if #(
    parameter int SAMPLE_W = 10
);
    logic                enable;
    logic [3:0]          channel;
    logic                new_sample;
    logic [SAMPLE_W-1:0] sample;
    logic [3:0]          sample_channel;
    logic [3:0]          rd_ch;
    logic [SAMPLE_W-1:0] rd_data;
    logic                upd_valid;
    logic [3:0]          upd_ch;
    logic [SAMPLE_W-1:0] upd_data;
    logic                timeout_err;
    logic                clr_err;

    modport master (
        output enable, new_sample, sample,
        output sample_channel, rd_ch, clr_err,
        input  channel, rd_data, upd_valid,
        input  upd_ch, upd_data, timeout_err
    );

    modport slave (
        input  enable, new_sample, sample,
        input  sample_channel, rd_ch, clr_err,
        output channel, rd_data, upd_valid,
        output upd_ch, upd_data, timeout_err
    );
endinterface

// File: rtl/multi_input_capture.sv
// Round-robin ADC channel scanner with per-channel hold registers.
// Define CAPTURE_AVG_EN to publish 4-sample averages instead of raw samples.
module multi_input_capture #(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 10,
    parameter int TIMEOUT  = 1023
) (
    input logic clk,
    input logic rst,
    multi_input_capture_if.slave bus
);
    localparam int CNT_W =
        (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TIMEOUT - 1);
    localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        UPDATE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cur_ch_q, cur_ch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] hold_q [NUM_CH];
    logic [SAMPLE_W-1:0] hold_d [NUM_CH];
    logic                upd_valid_q, upd_valid_d;
    logic [3:0]          upd_ch_q, upd_ch_d;
    logic [SAMPLE_W-1:0] upd_data_q, upd_data_d;
    logic                err_q, err_d;
    logic [3:0]          next_ch;
    logic                accept;
`ifdef CAPTURE_AVG_EN
    logic [SAMPLE_W+1:0] acc_q [NUM_CH];
    logic [SAMPLE_W+1:0] acc_d [NUM_CH];
    logic [1:0]          num_q [NUM_CH];
    logic [1:0]          num_d [NUM_CH];
    logic [SAMPLE_W+1:0] sum;
`endif

    assign next_ch = (cur_ch_q == LAST_CH)
                   ? 4'd0 : cur_ch_q + 4'd1;
    assign accept  = bus.new_sample
                   && (bus.sample_channel == cur_ch_q);

    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        upd_valid_d = 1'b0;
        upd_ch_d    = upd_ch_q;
        upd_data_d  = upd_data_q;
        err_d       = bus.clr_err ? 1'b0 : err_q;
`ifdef CAPTURE_AVG_EN
        acc_d = acc_q;
        num_d = num_q;
        sum   = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    state_d = UPDATE;
                    cnt_d   = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (cur_ch_q == 4'(i)) begin
`ifdef CAPTURE_AVG_EN
                            sum = acc_q[i]
                                + {2'b00, bus.sample};
                            if (num_q[i] == 2'd3) begin
                                hold_d[i]   = sum[SAMPLE_W+1:2];
                                acc_d[i]    = '0;
                                num_d[i]    = '0;
                                upd_valid_d = 1'b1;
                                upd_ch_d    = cur_ch_q;
                                upd_data_d  = sum[SAMPLE_W+1:2];
                            end else begin
                                acc_d[i] = sum;
                                num_d[i] = num_q[i] + 2'd1;
                            end
`else
                            hold_d[i]   = bus.sample;
                            upd_valid_d = 1'b1;
                            upd_ch_d    = cur_ch_q;
                            upd_data_d  = bus.sample;
`endif
                        end
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // skip the silent channel, keep scanning
                    cnt_d    = '0;
                    cur_ch_d = next_ch;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UPDATE: begin
                cur_ch_d = next_ch;
                cnt_d    = '0;
                state_d  = bus.enable ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_ch_q    <= '0;
            cnt_q       <= '0;
            hold_q      <= '{default: '0};
            upd_valid_q <= 1'b0;
            upd_ch_q    <= '0;
            upd_data_q  <= '0;
            err_q       <= 1'b0;
`ifdef CAPTURE_AVG_EN
            acc_q <= '{default: '0};
            num_q <= '{default: '0};
`endif
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            upd_valid_q <= upd_valid_d;
            upd_ch_q    <= upd_ch_d;
            upd_data_q  <= upd_data_d;
            err_q       <= err_d;
`ifdef CAPTURE_AVG_EN
            acc_q <= acc_d;
            num_q <= num_d;
`endif
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_ch == 4'(i)) begin
                bus.rd_data = hold_q[i];
            end
        end
    end

    assign bus.channel     = cur_ch_q;
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_ch      = upd_ch_q;
    assign bus.upd_data    = upd_data_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_multi_input_capture.sv
// Directed bench for multi_input_capture: NUM_CH=4, SAMPLE_W=10, TIMEOUT=15.
// Builds with or without CAPTURE_AVG_EN.
module tb_multi_input_capture;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passes = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    multi_input_capture_if #(.SAMPLE_W(10)) bus ();

    multi_input_capture #(
        .NUM_CH  (4),
        .SAMPLE_W(10),
        .TIMEOUT (15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h",
                    tag, obs, exp);
    endtask

    task automatic rd(input logic [3:0] ch,
                      input logic [9:0] exp);
        bus.rd_ch = ch;
        #1;
        chk($sformatf("rd_data[%0d]", ch),
            32'(bus.rd_data), 32'(exp));
    endtask

    task automatic send(input logic [3:0] ch,
                        input logic [9:0] v,
                        input logic       expv,
                        input logic [9:0] expd);
        bus.new_sample     = 1'b1;
        bus.sample_channel = ch;
        bus.sample         = v;
        tick();
        bus.new_sample = 1'b0;
        chk($sformatf("upd_valid ch%0d", ch),
            32'(bus.upd_valid), 32'(expv));
        if (expv) begin
            chk("upd_ch", 32'(bus.upd_ch), 32'(ch));
            chk("upd_data", 32'(bus.upd_data), 32'(expd));
        end
        tick();
        chk("strobe_one_cycle", 32'(bus.upd_valid), 32'd0);
    endtask

    initial begin
        logic [9:0] v4 [4];
        logic [9:0] avg_in [4];
        v4     = '{10'h100, 10'h200, 10'h300, 10'h3FF};
        avg_in = '{10'd10, 10'd11, 10'd12, 10'd14};
        bus.enable         = 1'b0;
        bus.new_sample     = 1'b0;
        bus.sample         = '0;
        bus.sample_channel = '0;
        bus.rd_ch          = '0;
        bus.clr_err        = 1'b0;
        tick();
        tick();
        chk("rst_channel", 32'(bus.channel), 32'd0);
        chk("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("rst_upd_ch", 32'(bus.upd_ch), 32'd0);
        chk("rst_upd_data", 32'(bus.upd_data), 32'd0);
        chk("rst_err", 32'(bus.timeout_err), 32'd0);
        rd(4'd0, 10'd0);
        rst = 1'b1;
        tick();
        bus.enable = 1'b1;
        tick();
`ifdef CAPTURE_AVG_EN
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                send(4'(c),
                     (c == 0) ? avg_in[r] : 10'd0,
                     r == 3,
                     (c == 0) ? 10'd11 : 10'd0);
            end
            if (r == 2) rd(4'd0, 10'd0);
        end
        rd(4'd0, 10'd11);
        chk("avg_channel_wrap", 32'(bus.channel), 32'd0);
`else
        for (int c = 0; c < 4; c++) begin
            send(4'(c), v4[c], 1'b1, v4[c]);
        end
        chk("scan_wrap", 32'(bus.channel), 32'd0);
        chk("upd_data_held", 32'(bus.upd_data), 32'h3FF);
        rd(4'd3, 10'h3FF);
        rd(4'd5, 10'd0);
        send(4'd0, 10'h011, 1'b1, 10'h011);
        bus.new_sample     = 1'b1;
        bus.sample_channel = 4'd2;
        bus.sample         = 10'h155;
        tick();
        bus.new_sample = 1'b0;
        chk("wrong_tag_valid", 32'(bus.upd_valid), 32'd0);
        chk("wrong_tag_channel", 32'(bus.channel), 32'd1);
        rd(4'd1, 10'h200);
        send(4'd1, 10'h0AA, 1'b1, 10'h0AA);
        chk("at_ch2", 32'(bus.channel), 32'd2);
        bus.new_sample     = 1'b1;
        bus.sample_channel = 4'd2;
        bus.sample         = 10'h0CC;
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus.upd_valid), 32'd0);
        chk("rst_mid_channel", 32'(bus.channel), 32'd0);
        tick();
        rst            = 1'b1;
        bus.new_sample = 1'b0;
        for (int c = 0; c < 4; c++) rd(4'(c), 10'd0);
        chk("rst_no_strobe", 32'(bus.upd_valid), 32'd0);
        for (int i = 0; i < 15; i++) tick();
        chk("pre_timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("pre_timeout_ch", 32'(bus.channel), 32'd0);
        tick();
        chk("timeout_err", 32'(bus.timeout_err), 32'd1);
        chk("timeout_ch", 32'(bus.channel), 32'd1);
        chk("timeout_no_strobe", 32'(bus.upd_valid), 32'd0);
        rd(4'd0, 10'd0);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("clr_err", 32'(bus.timeout_err), 32'd0);
        for (int i = 0; i < 13; i++) tick();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("clr_vs_timeout", 32'(bus.timeout_err), 32'd1);
        chk("timeout2_ch", 32'(bus.channel), 32'd2);
        send(4'd2, 10'h123, 1'b1, 10'h123);
        bus.enable = 1'b0;
        tick();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        tick();
        chk("pause_ch", 32'(bus.channel), 32'd3);
        chk("pause_err_clr", 32'(bus.timeout_err), 32'd0);
        bus.enable = 1'b1;
        tick();
        send(4'd3, 10'h321, 1'b1, 10'h321);
        chk("resume_wrap", 32'(bus.channel), 32'd0);
        rd(4'd3, 10'h321);
        for (int i = 0; i < 14; i++) tick();
        send(4'd0, 10'h0F0, 1'b1, 10'h0F0);
        chk("accept_beats_to", 32'(bus.timeout_err), 32'd0);
        chk("accept_beats_ch", 32'(bus.channel), 32'd1);
        rd(4'd0, 10'h0F0);
`endif
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/multi_input_capture.md
MULTI_INPUT_CAPTURE -- requirements
Module: multi_input_capture

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 8, meaning number of scanned channels (legal range 1..16).
REQ-002 The block SHALL have parameter SAMPLE_W, default 10, meaning ADC sample width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 1023, meaning the maximum number of cycles to wait for a sample before the channel is skipped.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: scan run/stop.
REQ-007 The block SHALL have port channel, output, 4 bits: ADC channel currently requested.
REQ-008 The block SHALL have port new_sample, input, 1 bit: ADC sample strobe.
REQ-009 The block SHALL have port sample, input, SAMPLE_W bits: ADC data.
REQ-010 The block SHALL have port sample_channel, input, 4 bits: channel tag of sample.
REQ-011 The block SHALL have port rd_ch, input, 4 bits: hold-register read select.
REQ-012 The block SHALL have port rd_data, output, SAMPLE_W bits: hold register[rd_ch], combinational; 0 when rd_ch >= NUM_CH.
REQ-013 The block SHALL have port upd_valid, output, 1 bit: one-cycle update strobe.
REQ-014 The block SHALL have port upd_ch, output, 4 bits: channel updated.
REQ-015 The block SHALL have port upd_data, output, SAMPLE_W bits: value written.
REQ-016 The block SHALL have port timeout_err, output, 1 bit: sticky skip flag.
REQ-017 The block SHALL have port clr_err, input, 1 bit: clears timeout_err.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT and UPDATE, with a current-channel index cur_ch, and channel SHALL equal cur_ch at all times.
- IDLE->WAIT when enable=1.
- WAIT->IDLE when enable=0; cur_ch is retained and the wait counter is cleared.
REQ-019 In WAIT, a sample SHALL be accepted only if new_sample=1 and sample_channel==cur_ch; samples with any other tag are ignored.
REQ-020 An accepted sample SHALL be written into the cur_ch hold register on the same edge, and the FSM SHALL go to UPDATE.
REQ-021 In UPDATE the block SHALL, for exactly one cycle:
- assert upd_valid=1 with upd_ch and upd_data showing the written channel and value;
- advance cur_ch (NUM_CH-1 wraps to 0);
- go to WAIT if enable=1, else IDLE.
REQ-022 Capture latency SHALL be: accepted strobe at edge N, upd_valid high for cycle N+1, channel shows the next index from N+2.
REQ-023 The wait counter SHALL clear on entry to WAIT; if it reaches TIMEOUT with no accepted sample, the block SHALL set timeout_err, leave the hold register unchanged, advance cur_ch, stay in WAIT, and not assert upd_valid.
REQ-024 A simultaneous accept and timeout SHALL resolve as accept.
REQ-025 If clr_err and a new timeout occur in the same cycle, timeout_err SHALL end set.
REQ-026 upd_ch and upd_data SHALL hold their last values while upd_valid=0.
REQ-027 When NUM_CH=1, cur_ch SHALL remain 0.

Reset
REQ-028 On rst=0, asynchronously:
- state=IDLE, cur_ch=0, channel=0;
- wait counter=0, all hold registers=0;
- upd_valid=0, upd_ch=0, upd_data=0, timeout_err=0;
- averaging state cleared.
REQ-029 A reset asserted mid-WAIT or mid-UPDATE SHALL discard the in-flight sample with no strobe; after release, the scan restarts at channel 0.

Configuration
REQ-030 When macro CAPTURE_AVG_EN is defined, each channel SHALL have a SAMPLE_W+2-bit accumulator and 2-bit count.
- Every accepted sample adds to the channel's accumulator.
- On the 4th sample, the hold register gets accumulator>>2 (truncated), accumulator and count clear, and UPDATE asserts upd_valid.
- On samples 1-3, UPDATE advances cur_ch without upd_valid and without changing the hold register.
- A timeout does not alter the accumulator.
REQ-031 Without CAPTURE_AVG_EN, every accepted sample SHALL be written directly and strobed, and no accumulator logic SHALL exist.

Verification
REQ-032 Scenario: NUM_CH=4, enable=1, feed tagged samples 0x100,0x200,0x300,0x3FF on ch0..3 -> four upd_valid pulses with upd_ch 0,1,2,3; rd_ch=3 reads 0x3FF; channel returns to 0.
REQ-033 Scenario: in WAIT on ch1, send sample 0x155 tagged ch2 -> no upd_valid, hold[1] unchanged, channel stays 1.
REQ-034 Scenario: TIMEOUT=15, no samples on ch0 -> after 15 cycles timeout_err=1, channel=1, hold[0]=0; pulse clr_err -> timeout_err=0.
REQ-035 Scenario: drop rst for one cycle mid-WAIT on ch2 while new_sample arrives -> no upd_valid, channel=0, all rd_data=0.
REQ-036 Scenario: enable=0 during WAIT on ch3, then re-assert enable -> channel stays 3 and the next accepted ch3 sample is captured.
REQ-037 Scenario (CAPTURE_AVG_EN): ch0 samples 10,11,12,14 -> a single upd_valid with upd_data=11 after the 4th sample.
